// File: rtl/fir_transpose_if.sv
// Sample-path and coefficient-port signals of fir_transpose.
// The slave modport is the filter side; the master modport is the driver side.
interface fir_transpose_if #(
    parameter int W = 12
);
    logic [W-1:0] Din;
    logic [W-1:0] Dout;
    logic [7:0]   write_address;
    logic [W-1:0] write_value;
    logic         load;
    logic [7:0]   read_address;
    logic [W-1:0] read_value;

    modport master (
        output Din, write_address, write_value, load, read_address,
        input  Dout, read_value
    );

    modport slave (
        input  Din, write_address, write_value, load, read_address,
        output Dout, read_value
    );
endinterface

// File: rtl/fir_transpose.sv
// Transposed-form FIR: one sample in, one saturated Q1.11-scaled sample out per clock,
// with a run-time writable and readable coefficient bank.
module fir_transpose #(
    parameter int TAPS      = 16,
    parameter int COEF_FRAC = 11,
    parameter int W         = 12
) (
    input  logic           Clk,
    input  logic           Hlt,
    fir_transpose_if.slave bus
);
    localparam int ACC = 2 * W + $clog2(TAPS);
    localparam int AW  = $clog2(TAPS);
    localparam logic signed [ACC-1:0] SAT_MAX = ACC'((2 ** (W - 1)) - 1);
    localparam logic signed [ACC-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [W-1:0]   coef_q [TAPS];
    logic signed [W-1:0]   coef_d [TAPS];
    logic signed [2*W-1:0] mul_s  [TAPS];
    logic signed [ACC-1:0] prod_s [TAPS];
    logic signed [ACC-1:0] z_q    [1:TAPS-1];
    logic signed [ACC-1:0] z_d    [1:TAPS-1];
    logic signed [ACC-1:0] y_s;
    logic signed [ACC-1:0] y_shift_s;
    logic signed [W-1:0]   dout_q;
    logic signed [W-1:0]   dout_d;
    logic                  wr_hit_s;
    logic                  rd_hit_s;

    function automatic logic signed [W-1:0] sat_w(input logic signed [ACC-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[W-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[W-1:0];
        end else begin
            return v[W-1:0];
        end
    endfunction

    // Coefficient write decode; out-of-range addresses leave the bank untouched.
    always_comb begin
        wr_hit_s = bus.load && ({24'd0, bus.write_address} < TAPS);
        for (int k = 0; k < TAPS; k++) begin
            coef_d[k] = (wr_hit_s && (bus.write_address[AW-1:0] == AW'(k)))
                        ? $signed(bus.write_value) : coef_q[k];
        end
    end

    // Coefficient bank: deliberately outside Hlt so a halt never loses the filter setup.
    always_ff @(posedge Clk) begin
        coef_q <= coef_d;
    end

    assign rd_hit_s       = ({24'd0, bus.read_address} < TAPS);
    assign bus.read_value = rd_hit_s ? coef_q[bus.read_address[AW-1:0]] : {W{1'b0}};

    // Products use the bank as it stood before this edge, so a new coefficient
    // only affects samples entering from the next edge onward.
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            mul_s[k]  = $signed(bus.Din) * coef_q[k];
            prod_s[k] = ACC'(mul_s[k]);
        end
        z_d[TAPS-1] = prod_s[TAPS-1];
        for (int k = 1; k < TAPS - 1; k++) begin
            z_d[k] = prod_s[k] + z_q[k+1];
        end
        y_s       = prod_s[0] + z_q[1];
        y_shift_s = y_s >>> COEF_FRAC;
        dout_d    = sat_w(y_shift_s);
    end

    // Partial-sum chain and output register; Hlt discards all history.
    always_ff @(posedge Clk or posedge Hlt) begin
        if (Hlt) begin
            z_q    <= '{default: '0};
            dout_q <= '0;
        end else begin
            z_q    <= z_d;
            dout_q <= dout_d;
        end
    end

    assign bus.Dout = dout_q;
endmodule

// File: tb/tb_fir_transpose.sv
// Directed and random checks of fir_transpose against a direct-form reference that
// remembers which coefficient bank each sample saw on entry.
module tb_fir_transpose;
    logic Clk = 1'b0;
    logic Hlt;

    fir_transpose_if #(.W(12)) bus ();

    fir_transpose #(.TAPS(16), .COEF_FRAC(11), .W(12)) dut (
        .Clk (Clk),
        .Hlt (Hlt),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int mc [16];
    int xh [16];
    int ch [16][16];
    int exp_dout;

    task automatic clear_history();
        for (int j = 0; j < 16; j++) xh[j] = 0;
    endtask

    // Advance one filtering edge; the model product for tap k uses the bank seen k edges ago.
    task automatic tick();
        longint acc;
        for (int j = 15; j > 0; j--) begin
            xh[j] = xh[j-1];
            ch[j] = ch[j-1];
        end
        xh[0] = int'($signed(bus.Din));
        ch[0] = mc;
        acc = 0;
        for (int k = 0; k < 16; k++) acc += longint'(ch[k][k]) * longint'(xh[k]);
        acc = acc >>> 11;
        exp_dout = (acc > 2047) ? 2047 : ((acc < -2048) ? -2048 : int'(acc));
        if (bus.load && (bus.write_address < 8'd16))
            mc[bus.write_address[3:0]] = int'($signed(bus.write_value));
        @(posedge Clk);
        #1;
    endtask

    task automatic write_coef(input logic [7:0] addr, input logic [11:0] val);
        bus.load          = 1'b1;
        bus.write_address = addr;
        bus.write_value   = val;
        if (Hlt) begin
            if (addr < 8'd16) mc[addr[3:0]] = int'($signed(val));
            @(posedge Clk);
            #1;
        end else begin
            tick();
        end
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        Hlt = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (bus.Dout !== 12'h000) begin
            errors++;
            $display("FAIL reset_dout got %h exp 000", bus.Dout);
        end
        bus.Din = 12'd100;
        for (int k = 0; k < 16; k++) write_coef(8'(k), 12'(k + 1));
        checks++;
        if (bus.Dout !== 12'h000) begin
            errors++;
            $display("FAIL reset_hold got %h exp 000", bus.Dout);
        end
        bus.read_address = 8'd5;
        #1;
        checks++;
        if (bus.read_value !== 12'd6) begin
            errors++;
            $display("FAIL write_in_reset got %h exp 006", bus.read_value);
        end
        bus.Din = 12'd0;
        clear_history();
        Hlt = 1'b0;
    endtask

    task automatic test_impulse();
        for (int k = 0; k < 18; k++) begin
            bus.Din = (k == 0) ? 12'd1024 : 12'd0;
            tick();
            checks++;
            if (int'($signed(bus.Dout)) !== ((k < 16) ? (k + 1) / 2 : 0)) begin
                errors++;
                $display("FAIL impulse k=%0d got %0d exp %0d", k, $signed(bus.Dout),
                         (k < 16) ? (k + 1) / 2 : 0);
            end
        end
    endtask

    task automatic test_passthrough();
        bus.Din = 12'd0;
        write_coef(8'd0, 12'h7FF);
        for (int k = 1; k < 16; k++) write_coef(8'(k), 12'h000);
        for (int i = 0; i < 20; i++) begin
            bus.Din = 12'(i * 100);
            tick();
            checks++;
            if (int'($signed(bus.Dout)) !== (i * 100 * 2047) / 2048) begin
                errors++;
                $display("FAIL passthrough din=%0d got %0d exp %0d", i * 100, $signed(bus.Dout),
                         (i * 100 * 2047) / 2048);
            end
        end
    endtask

    task automatic test_saturation();
        bus.Din = 12'd0;
        for (int k = 0; k < 16; k++) write_coef(8'(k), 12'h7FF);
        bus.Din = 12'h800;
        tick();
        checks++;
        if (bus.Dout !== 12'h801) begin
            errors++;
            $display("FAIL neg_first got %h exp 801", bus.Dout);
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (bus.Dout !== 12'h800) begin
                errors++;
                $display("FAIL neg_sat i=%0d got %h exp 800", i, bus.Dout);
            end
        end
        bus.Din = 12'hFFF;
        repeat (16) tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.Dout !== 12'hFF0) begin
                errors++;
                $display("FAIL minus_one i=%0d got %h exp ff0", i, bus.Dout);
            end
            tick();
        end
        bus.Din = 12'h7FF;
        repeat (16) tick();
        checks++;
        if (bus.Dout !== 12'h7FF) begin
            errors++;
            $display("FAIL pos_sat got %h exp 7ff", bus.Dout);
        end
    endtask

    task automatic test_readback();
        bus.Din          = 12'd0;
        bus.read_address = 8'd3;
        write_coef(8'd3, 12'hFFB);
        checks++;
        if (bus.read_value !== 12'hFFB) begin
            errors++;
            $display("FAIL readback_3 got %h exp ffb", bus.read_value);
        end
        bus.read_address = 8'd200;
        write_coef(8'd200, 12'd77);
        checks++;
        if (bus.read_value !== 12'h000) begin
            errors++;
            $display("FAIL readback_200 got %h exp 000", bus.read_value);
        end
        for (int a = 0; a < 16; a++) begin
            bus.read_address = 8'(a);
            #1;
            checks++;
            if (bus.read_value !== ((a == 3) ? 12'hFFB : 12'h7FF)) begin
                errors++;
                $display("FAIL readback_keep a=%0d got %h exp %h", a, bus.read_value,
                         (a == 3) ? 12'hFFB : 12'h7FF);
            end
        end
    endtask

    task automatic test_random();
        bus.Din = 12'd0;
        for (int k = 0; k < 16; k++) write_coef(8'(k), 12'($urandom));
        for (int i = 0; i < 1000; i++) begin
            bus.Din           = 12'($urandom);
            bus.load          = ($urandom_range(0, 9) == 0);
            bus.write_address = 8'($urandom_range(0, 31));
            bus.write_value   = 12'($urandom);
            tick();
            checks++;
            if (int'($signed(bus.Dout)) !== exp_dout) begin
                errors++;
                $display("FAIL random i=%0d got %0d exp %0d", i, $signed(bus.Dout), exp_dout);
            end
        end
        bus.load = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 20; i++) begin
            bus.Din = 12'($urandom);
            tick();
        end
        #3;
        Hlt = 1'b1;
        #1;
        checks++;
        if (bus.Dout !== 12'h000) begin
            errors++;
            $display("FAIL mid_reset_dout got %h exp 000", bus.Dout);
        end
        clear_history();
        bus.read_address = 8'd7;
        bus.Din          = 12'h5A5;
        #1;
        checks++;
        if (int'($signed(bus.read_value)) !== mc[7]) begin
            errors++;
            $display("FAIL mid_reset_coef got %0d exp %0d", $signed(bus.read_value), mc[7]);
        end
        repeat (2) @(posedge Clk);
        #1;
        Hlt = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.Din = 12'($urandom);
            tick();
            checks++;
            if (int'($signed(bus.Dout)) !== exp_dout) begin
                errors++;
                $display("FAIL post_reset i=%0d got %0d exp %0d", i, $signed(bus.Dout), exp_dout);
            end
        end
    endtask

    initial begin
        Hlt               = 1'b1;
        bus.Din           = 12'd0;
        bus.load          = 1'b0;
        bus.write_address = 8'd0;
        bus.write_value   = 12'd0;
        bus.read_address  = 8'd0;
        for (int k = 0; k < 16; k++) mc[k] = 0;
        for (int j = 0; j < 16; j++) ch[j] = mc;
        clear_history();
        test_reset();
        test_impulse();
        test_passthrough();
        test_saturation();
        test_readback();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
